spi_rx_regbank: RTL and testbench

SPI receive register bank: the receive end of the test-pattern SPI link. It oversamples the incoming SPI clock, serial data and active-low enable on `sys_clk`. It deserialises MSB-first 16-bit words, groups four consecutive words (A, B, C, Corr) into one coefficient set, and presents each completed set on parallel outputs with a one-cycle valid strobe. It sits between the SPI pads and the coefficient/correction logic.

---
 rtl/spi_rx_regbank.sv | 199 +++++++++++++++++++
 tb/tb_spi_rx_regbank.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_rx_regbank.sv
// spi_rx_regbank: receive end of the test-pattern SPI link.
// Oversamples spi_clk / spi_in / spi_en on sys_clk. Deserialises MSB-first
// WORD_W-bit words and groups WORDS_PER_SET words (A, B, C, Corr) into one
// coefficient set. Each completed set is presented with a one-cycle strobe.
//
// Ports:
//   sys_clk, rst_n      system clock, synchronous active-low reset
//   spi_clk, spi_in     raw SPI clock and serial data (asynchronous)
//   spi_en              raw active-low transfer enable (1 = idle)
//   reg_a..reg_corr     last committed set
//   set_idx             index of the last committed set (wraps 3->0)
//   set_valid           one-cycle pulse when a set is committed
//   frame_err           one-cycle pulse when a transfer aborts mid-word/mid-set
//   busy                synchronised transfer-in-progress flag
module spi_rx_regbank #(
  parameter int unsigned WORD_W        = 16,
  parameter int unsigned WORDS_PER_SET = 4,
  parameter int unsigned SYNC_STAGES   = 2
) (
  input  logic              sys_clk,
  input  logic              rst_n,
  input  logic              spi_clk,
  input  logic              spi_in,
  input  logic              spi_en,
  output logic [WORD_W-1:0] reg_a,
  output logic [WORD_W-1:0] reg_b,
  output logic [WORD_W-1:0] reg_c,
  output logic [WORD_W-1:0] reg_corr,
  output logic [1:0]        set_idx,
  output logic              set_valid,
  output logic              frame_err,
  output logic              busy
);

  localparam int unsigned BitCntW   = $clog2(WORD_W);
  localparam int unsigned WordCntW  = $clog2(WORDS_PER_SET);
  localparam int unsigned NumShadow = WORDS_PER_SET - 1;

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  // Synchronisers: equal depth keeps data aligned with its clock edge.
  logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
  logic [SYNC_STAGES-1:0] in_sync_q, in_sync_d;
  logic [SYNC_STAGES-1:0] en_sync_q, en_sync_d;
  logic                   spi_clk_s, spi_in_s, spi_en_s;
  logic                   clk_prev_q, clk_prev_d;

  state_e state_q, state_d;
  logic   bit_stb, shift_en, abort;

  logic [WORD_W-1:0]                  shift_q, shift_d, word_full;
  logic [BitCntW-1:0]                 bit_cnt_q, bit_cnt_d;
  logic [WordCntW-1:0]                word_cnt_q, word_cnt_d;
  logic [NumShadow-1:0][WORD_W-1:0]   shadow_q, shadow_d;
  logic [1:0]                         set_cnt_q, set_cnt_d;
  logic                               word_done, set_done;

  logic [WORD_W-1:0] reg_a_q, reg_a_d, reg_b_q, reg_b_d;
  logic [WORD_W-1:0] reg_c_q, reg_c_d, reg_corr_q, reg_corr_d;
  logic [1:0]        set_idx_q, set_idx_d;
  logic              set_valid_q, set_valid_d;
  logic              frame_err_q, frame_err_d;

  always_comb begin
    clk_sync_d = {clk_sync_q[SYNC_STAGES-2:0], spi_clk};
    in_sync_d  = {in_sync_q[SYNC_STAGES-2:0], spi_in};
    en_sync_d  = {en_sync_q[SYNC_STAGES-2:0], spi_en};
    clk_prev_d = spi_clk_s;
  end

  assign spi_clk_s = clk_sync_q[SYNC_STAGES-1];
  assign spi_in_s  = in_sync_q[SYNC_STAGES-1];
  assign spi_en_s  = en_sync_q[SYNC_STAGES-1];
  assign bit_stb   = spi_clk_s & ~clk_prev_q;

  // FSM: state register
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (!spi_en_s) state_d = StShift;
      StShift: if (spi_en_s)  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM: outputs. Shifting keys off the live enable so the first bit after
  // the enable falls is not lost; a clock edge coinciding with the enable
  // rising is treated as idle.
  always_comb begin
    shift_en = bit_stb & ~spi_en_s;
    abort    = (state_q == StShift) & spi_en_s;
  end

  // Datapath next state
  always_comb begin
    word_full   = {shift_q[WORD_W-2:0], spi_in_s};
    word_done   = shift_en && (bit_cnt_q == BitCntW'(WORD_W - 1));
    set_done    = word_done && (word_cnt_q == WordCntW'(WORDS_PER_SET - 1));

    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    word_cnt_d  = word_cnt_q;
    shadow_d    = shadow_q;
    set_cnt_d   = set_cnt_q;
    reg_a_d     = reg_a_q;
    reg_b_d     = reg_b_q;
    reg_c_d     = reg_c_q;
    reg_corr_d  = reg_corr_q;
    set_idx_d   = set_idx_q;
    set_valid_d = 1'b0;
    frame_err_d = 1'b0;

    if (abort) begin
      // Partial data is discarded; set counter and outputs are kept.
      frame_err_d = (bit_cnt_q != '0) || (word_cnt_q != '0);
      shift_d     = '0;
      bit_cnt_d   = '0;
      word_cnt_d  = '0;
      shadow_d    = '0;
    end else if (shift_en) begin
      shift_d   = word_full;
      bit_cnt_d = bit_cnt_q + 1'b1;
      if (word_done) begin
        bit_cnt_d = '0;
        if (set_done) begin
          // Last word bypasses the shadows and commits with the others.
          word_cnt_d  = '0;
          reg_a_d     = shadow_q[0];
          reg_b_d     = shadow_q[1];
          reg_c_d     = shadow_q[2];
          reg_corr_d  = word_full;
          set_idx_d   = set_cnt_q;
          set_cnt_d   = set_cnt_q + 2'd1;
          set_valid_d = 1'b1;
        end else begin
          shadow_d[word_cnt_q] = word_full;
          word_cnt_d           = word_cnt_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      clk_sync_q  <= '0;
      in_sync_q   <= '0;
      en_sync_q   <= '1;  // enable resets to idle
      clk_prev_q  <= 1'b0;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      word_cnt_q  <= '0;
      shadow_q    <= '0;
      set_cnt_q   <= '0;
      reg_a_q     <= '0;
      reg_b_q     <= '0;
      reg_c_q     <= '0;
      reg_corr_q  <= '0;
      set_idx_q   <= '0;
      set_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      clk_sync_q  <= clk_sync_d;
      in_sync_q   <= in_sync_d;
      en_sync_q   <= en_sync_d;
      clk_prev_q  <= clk_prev_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      word_cnt_q  <= word_cnt_d;
      shadow_q    <= shadow_d;
      set_cnt_q   <= set_cnt_d;
      reg_a_q     <= reg_a_d;
      reg_b_q     <= reg_b_d;
      reg_c_q     <= reg_c_d;
      reg_corr_q  <= reg_corr_d;
      set_idx_q   <= set_idx_d;
      set_valid_q <= set_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign reg_a     = reg_a_q;
  assign reg_b     = reg_b_q;
  assign reg_c     = reg_c_q;
  assign reg_corr  = reg_corr_q;
  assign set_idx   = set_idx_q;
  assign set_valid = set_valid_q;
  assign frame_err = frame_err_q;
  assign busy      = ~spi_en_s;

endmodule

// File: tb/tb_spi_rx_regbank.sv
// Testbench for spi_rx_regbank: drives SPI frames and compares committed sets
// against a word-grouping model of the link.
module tb_spi_rx_regbank;

  logic        sys_clk = 1'b0;
  logic        rst_n   = 1'b0;
  logic        spi_clk = 1'b0;
  logic        spi_in  = 1'b0;
  logic        spi_en  = 1'b1;
  logic [15:0] reg_a, reg_b, reg_c, reg_corr;
  logic [1:0]  set_idx;
  logic        set_valid, frame_err, busy;

  spi_rx_regbank #(
    .WORD_W       (16),
    .WORDS_PER_SET(4),
    .SYNC_STAGES  (2)
  ) dut (
    .sys_clk  (sys_clk),
    .rst_n    (rst_n),
    .spi_clk  (spi_clk),
    .spi_in   (spi_in),
    .spi_en   (spi_en),
    .reg_a    (reg_a),
    .reg_b    (reg_b),
    .reg_c    (reg_c),
    .reg_corr (reg_corr),
    .set_idx  (set_idx),
    .set_valid(set_valid),
    .frame_err(frame_err),
    .busy     (busy)
  );

  always #5 sys_clk = ~sys_clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Observation of every set_valid / frame_err pulse.
  typedef struct {
    logic [15:0] a, b, c, corr;
    logic [1:0]  idx;
    int unsigned cyc;
  } obs_t;
  obs_t        obs_q[$];
  int unsigned cyc      = 0;
  int          fe_cnt   = 0;
  int          both_cnt = 0;
  int          dbl_cnt  = 0;
  logic        sv_prev  = 1'b0;
  logic        fe_prev  = 1'b0;

  always @(posedge sys_clk) begin
    cyc = cyc + 1;
    #1;
    if (set_valid) obs_q.push_back('{reg_a, reg_b, reg_c, reg_corr, set_idx, cyc});
    if (frame_err) fe_cnt++;
    if (set_valid && frame_err) both_cnt++;
    if ((set_valid && sv_prev) || (frame_err && fe_prev)) dbl_cnt++;
    sv_prev = set_valid;
    fe_prev = frame_err;
  end

  // Reference model: words are grouped four at a time into sets.
  typedef struct {
    logic [15:0] a, b, c, corr;
    int          idx;
    int unsigned rise;
  } exp_t;
  exp_t        exp_q[$];
  logic [15:0] m_words[$];
  int          m_bits = 0;
  int          m_idx  = 0;
  int          m_fe   = 0;
  logic [15:0] m_last[4] = '{16'h0, 16'h0, 16'h0, 16'h0};
  int          rd     = 0;

  int          half = 3;
  int          skew = 5;
  int unsigned last_rise = 0;

  logic [15:0] fixed_w[16] = '{
    16'hFFFF, 16'hFFFF, 16'h0003, 16'hFFFF,
    16'h4431, 16'h1123, 16'h0000, 16'h5554,
    16'hFFFF, 16'h0000, 16'h0007, 16'h0000,
    16'h0000, 16'h0000, 16'h0004, 16'h0000
  };

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge sys_clk);
    #(skew);
  endtask

  task automatic send_bit(input logic b);
    spi_clk = 1'b0;
    spi_in  = b;
    tick(half);
    spi_clk   = 1'b1;
    last_rise = cyc;
    tick(half);
  endtask

  task automatic send_word(input logic [15:0] w, input int nbits);
    for (int i = 15; i > 15 - nbits; i--) send_bit(w[i]);
    if (nbits == 16) begin
      m_words.push_back(w);
      if (m_words.size() == 4) begin
        exp_q.push_back('{m_words[0], m_words[1], m_words[2], m_words[3], m_idx, last_rise});
        m_last = '{m_words[0], m_words[1], m_words[2], m_words[3]};
        m_idx  = (m_idx + 1) % 4;
        m_words.delete();
      end
    end else begin
      m_bits = nbits;
    end
  endtask

  task automatic send_set(input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] c, input logic [15:0] corr);
    send_word(a, 16);
    send_word(b, 16);
    send_word(c, 16);
    send_word(corr, 16);
  endtask

  task automatic frame_begin();
    spi_clk = 1'b0;
    spi_en  = 1'b0;
    tick(4);
  endtask

  task automatic frame_end();
    spi_clk = 1'b0;
    tick(half);
    spi_en = 1'b1;
    if (m_words.size() != 0 || m_bits != 0) m_fe++;
    m_words.delete();
    m_bits = 0;
    tick(6);
  endtask

  task automatic check_sets(input string tag);
    chk($sformatf("%s_set_count", tag), obs_q.size(), exp_q.size());
    while (rd < exp_q.size() && rd < obs_q.size()) begin
      chk($sformatf("%s_s%0d_a", tag, rd), obs_q[rd].a, exp_q[rd].a);
      chk($sformatf("%s_s%0d_b", tag, rd), obs_q[rd].b, exp_q[rd].b);
      chk($sformatf("%s_s%0d_c", tag, rd), obs_q[rd].c, exp_q[rd].c);
      chk($sformatf("%s_s%0d_corr", tag, rd), obs_q[rd].corr, exp_q[rd].corr);
      chk($sformatf("%s_s%0d_idx", tag, rd), obs_q[rd].idx, exp_q[rd].idx);
      chk($sformatf("%s_s%0d_latency", tag, rd), obs_q[rd].cyc - exp_q[rd].rise, 3);
      rd++;
    end
    chk($sformatf("%s_frame_err_count", tag), fe_cnt, m_fe);
  endtask

  task automatic check_regs(input string tag);
    chk($sformatf("%s_reg_a", tag), reg_a, m_last[0]);
    chk($sformatf("%s_reg_b", tag), reg_b, m_last[1]);
    chk($sformatf("%s_reg_c", tag), reg_c, m_last[2]);
    chk($sformatf("%s_reg_corr", tag), reg_corr, m_last[3]);
  endtask

  task automatic check_zero(input string tag);
    chk($sformatf("%s_reg_a", tag), reg_a, 0);
    chk($sformatf("%s_reg_b", tag), reg_b, 0);
    chk($sformatf("%s_reg_c", tag), reg_c, 0);
    chk($sformatf("%s_reg_corr", tag), reg_corr, 0);
    chk($sformatf("%s_set_idx", tag), set_idx, 0);
    chk($sformatf("%s_set_valid", tag), set_valid, 0);
    chk($sformatf("%s_frame_err", tag), frame_err, 0);
    chk($sformatf("%s_busy", tag), busy, 0);
  endtask

  logic [15:0] r[4];

  initial begin
    // Reset state
    rst_n = 1'b0;
    tick(3);
    check_zero("reset");
    rst_n = 1'b1;
    tick(3);

    // Fixed 256-bit stream; busy lags the raw enable by two cycles
    spi_en = 1'b0;
    tick(1);
    chk("busy_lag1", busy, 0);
    tick(1);
    chk("busy_lag2", busy, 1);
    tick(2);
    for (int i = 0; i < 16; i++) begin
      send_word(fixed_w[i], 16);
      if (i == 8) chk("busy_mid_stream", busy, 1);
    end
    frame_end();
    check_sets("stream");
    chk("busy_after_stream", busy, 0);

    // Idle clocks with enable high, then set 0 again with wrapped index
    for (int i = 0; i < 10; i++) begin
      spi_clk = 1'b1;
      tick(half);
      spi_clk = 1'b0;
      tick(half);
    end
    frame_begin();
    send_set(16'hFFFF, 16'hFFFF, 16'h0003, 16'hFFFF);
    frame_end();
    check_sets("resend");

    // Abort after 7 bits of word B
    frame_begin();
    send_word(16'($urandom), 16);
    send_word(16'($urandom), 7);
    frame_end();
    check_sets("abort");
    check_regs("abort_hold");
    frame_begin();
    for (int i = 0; i < 4; i++) r[i] = 16'($urandom);
    send_set(r[0], r[1], r[2], r[3]);
    frame_end();
    check_sets("after_abort");

    // SPI clock toggling while idle
    for (int i = 0; i < 20; i++) begin
      spi_in  = 1'($urandom);
      spi_clk = 1'b1;
      tick(half);
      spi_clk = 1'b0;
      tick(half);
    end
    chk("idle_toggle_busy", busy, 0);
    check_sets("idle_toggle");
    check_regs("idle_toggle_hold");

    // Reset in the middle of word C
    frame_begin();
    send_set(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
    send_word(16'($urandom), 16);
    send_word(16'($urandom), 16);
    send_word(16'($urandom), 5);
    spi_clk = 1'b0;
    tick(1);
    rst_n = 1'b0;
    tick(1);
    check_zero("mid_reset");
    rst_n  = 1'b1;
    spi_en = 1'b1;
    m_words.delete();
    m_bits = 0;
    m_idx  = 0;
    m_last = '{16'h0, 16'h0, 16'h0, 16'h0};
    tick(6);
    check_sets("pre_reset");
    frame_begin();
    for (int i = 0; i < 4; i++) r[i] = 16'($urandom);
    send_set(r[0], r[1], r[2], r[3]);
    frame_end();
    check_sets("post_reset");

    // spi_clk at sys_clk/6, phase swept across one SPI period
    for (int i = 0; i < 4; i++) r[i] = 16'($urandom);
    for (int off = 0; off < 6; off++) begin
      skew = 2 + off;
      tick(1 + off);
      frame_begin();
      send_set(r[0], r[1], r[2], r[3]);
      frame_end();
      check_sets($sformatf("sweep%0d", off));
    end
    skew = 5;
    tick(4);

    chk("valid_and_err_together", both_cnt, 0);
    chk("pulse_wider_than_one", dbl_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
